// File: rtl/hpdmc_rdcapture.sv
// Read-data capture for the DDR SDRAM controller: finds the CAS-delayed burst
// window and packs each rising/falling DQ beat pair into one registered word.
module hpdmc_rdcapture #(
    parameter int DQ_WIDTH = 16,
    parameter int BURST    = 4,
    parameter int MAX_LAT  = 7
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  read_issue,
    input  logic [2:0]            cas_lat,
    input  logic [DQ_WIDTH-1:0]   iddr_q0,
    input  logic [DQ_WIDTH-1:0]   iddr_q1,
    input  logic                  clr_err,
    output logic [2*DQ_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  overrun
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [MAX_LAT:1]   dly;
    logic [2:0]         lat;
    logic               tap, capture, last, ovr_set;

    // dly[i] is read_issue delayed by i cycles
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dly <= '0;
        end else begin
            dly[1] <= read_issue;
            for (int i = 2; i <= MAX_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    always_comb begin
        lat = cas_lat;
        if (cas_lat == 3'd0)
            lat = 3'd1;
        else if (int'(cas_lat) > MAX_LAT)
            lat = 3'(MAX_LAT);
    end

    always_comb begin
        tap = 1'b0;
        for (int i = 1; i <= MAX_LAT; i++)
            if (int'(lat) == i) tap = dly[i];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        last    = 1'b0;
        ovr_set = 1'b0;
        case (state)
            IDLE: begin
                if (tap) begin
                    capture = 1'b1;
                    cnt_n   = CW'(1);
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                if (cnt == CW'(BURST - 1)) begin
                    last = 1'b1;
                    if (tap) begin
                        cnt_n = CW'(1);
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end else if (tap) begin
                    // New burst arrived early: drop the old one, this beat starts the new one
                    ovr_set = 1'b1;
                    cnt_n   = CW'(1);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            rd_valid <= capture;
            rd_last  <= last;
            if (capture) rd_data <= {iddr_q0, iddr_q1};
            overrun  <= ovr_set | (overrun & ~clr_err);
        end
    end

endmodule

// File: tb/tb_hpdmc_rdcapture.sv
// Scoreboard bench for hpdmc_rdcapture: expected words are queued when reads
// are issued and matched against rd_valid/rd_data/rd_last as they emerge.
module tb_hpdmc_rdcapture;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        read_issue = 1'b0;
    logic [2:0]  cas_lat = 3'd3;
    logic [15:0] iddr_q0 = '0;
    logic [15:0] iddr_q1 = '0;
    logic        clr_err = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, overrun;

    int vec = 0;
    int err = 0;
    int rel = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];

    hpdmc_rdcapture #(.DQ_WIDTH(16), .BURST(4), .MAX_LAT(7)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .read_issue(read_issue),
        .cas_lat(cas_lat), .iddr_q0(iddr_q0), .iddr_q1(iddr_q1),
        .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_last(rd_last), .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h (rel cycle %0d)", tag, got, exp, rel);
        end
    endtask

    // Pair driven in relative cycle r; cycles 3..6 give 1111/2222 .. 7777/8888
    function automatic logic [31:0] dat(input int r);
        int k1, k0;
        k1 = (2 * r - 5) * 32'h1111;
        k0 = (2 * r - 4) * 32'h1111;
        return {k0[15:0], k1[15:0]};
    endfunction

    task automatic push_words(input int s, input int n, input bit last_end);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.cyc  = s + i + 1;
            e.data = dat(s + i);
            e.last = last_end && (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic step(input bit iss, input bit clr);
        read_issue = iss;
        clr_err    = clr;
        {iddr_q0, iddr_q1} = dat(rel);
        @(posedge sys_clk);
        #1;
        rel++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        idle(6);
        chk(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic single(input logic [2:0] l, input int leff);
        cas_lat = l;
        rel = 0;
        push_words(leff, 4, 1'b1);
        step(1'b1, 1'b0);
        idle(leff + 4);
        drain("single_drain");
    endtask

    always @(negedge sys_clk) begin
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", {31'd0, rd_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_cycle", 32'(rel), 32'(e.cyc));
                chk("data", rd_data, e.data);
                chk("last", {31'd0, rd_last}, {31'd0, e.last});
            end
        end else begin
            chk("last_no_valid", {31'd0, rd_last}, 32'd0);
            if (sb.size() > 0 && sb[0].cyc < rel) begin
                chk("missing_word", 32'(sb[0].cyc), 32'(rel));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #1 sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_data", rd_data, 32'd0);
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        sys_rst_n = 1'b1;
        rel = 0;
        for (int c = 0; c < 20; c++) begin
            chk("idle_data", rd_data, 32'd0);
            chk("idle_ovr", {31'd0, overrun}, 32'd0);
            step(1'b0, 1'b0);
        end

        // single burst L=3
        single(3'd3, 3);

        // back-to-back, reads BURST apart
        cas_lat = 3'd2;
        rel = 0;
        push_words(2, 4, 1'b1);
        push_words(6, 4, 1'b1);
        for (int c = 0; c < 12; c++) step(c == 0 || c == 4, 1'b0);
        chk("b2b_ovr", {31'd0, overrun}, 32'd0);
        drain("b2b_drain");

        // overrun: issues at 0 and 2
        rel = 0;
        push_words(2, 2, 1'b0);
        push_words(4, 4, 1'b1);
        for (int c = 0; c < 12; c++) begin
            if (c == 4) chk("ovr_pre", {31'd0, overrun}, 32'd0);
            if (c == 5) chk("ovr_set", {31'd0, overrun}, 32'd1);
            step(c == 0 || c == 2, 1'b0);
        end
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        drain("ovr_drain");

        // overrun coincident with clr_err: set wins; then clear alone
        rel = 0;
        push_words(2, 1, 1'b0);
        push_words(3, 4, 1'b1);
        for (int c = 0; c < 11; c++) begin
            if (c == 4)  chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
            if (c == 10) chk("ovr_cleared", {31'd0, overrun}, 32'd0);
            step(c == 0 || c == 1, c == 3 || c == 9);
        end
        drain("ovr2_drain");

        // latency sweep
        single(3'd1, 1);
        single(3'd7, 7);
        single(3'd0, 1);

        // reset mid-burst, L=3
        cas_lat = 3'd3;
        rel = 0;
        push_words(3, 1, 1'b0);
        step(1'b1, 1'b0);
        idle(4);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, rd_valid}, 32'd0);
        chk("mrst_data", rd_data, 32'd0);
        chk("mrst_last", {31'd0, rd_last}, 32'd0);
        idle(2);
        sys_rst_n = 1'b1;
        idle(10);
        chk("mrst_data_after", rd_data, 32'd0);
        drain("mrst_drain");
        single(3'd3, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/hpdmc_rdcapture.md
# hpdmc_rdcapture

Read-data capture stage of the 16-bit DDR SDRAM controller, directly downstream of the input DDR registers on the DQ pins. It consumes the per-clock rising/falling data pair they produce, uses the controller's READ-issue strobe and the programmed CAS latency to find the valid burst window, and packs each beat pair into a 32-bit word. The words go to the controller's read data path with valid/last qualifiers and a sticky overrun flag.

## Interface

- `DQ_WIDTH`, 16: width of each input DDR register output (one DQ beat).
- `BURST`, 4: system-clock beats per read burst (DDR burst length 8); power of two, ≥2.
- `MAX_LAT`, 7: largest supported CAS-to-capture delay in system clocks; sets the delay-line length.

- `sys_clk`  in  1: system clock; drives the C0 side of the input DDR registers.
- `sys_rst_n`  in  1: asynchronous, active-low reset.
- `read_issue`  in  1: one-cycle pulse, high in the cycle a READ command is driven to the SDRAM.
- `cas_lat`  in  3: delay in sys_clk cycles from `read_issue` to the first capture cycle, 1..MAX_LAT.
- `iddr_q0`  in  DQ_WIDTH: rising-edge beat (later beat of the pair).
- `iddr_q1`  in  DQ_WIDTH: falling-edge beat retimed to the rising edge (earlier beat of the pair).
- `clr_err`  in  1: clears `overrun`.
- `rd_data`  out  2*DQ_WIDTH: packed word; [DQ_WIDTH-1:0] = `iddr_q1`, [2*DQ_WIDTH-1:DQ_WIDTH] = `iddr_q0`.
- `rd_valid`  out  1: `rd_data` holds a valid burst word this cycle.
- `rd_last`  out  1: final word of a burst; only high with `rd_valid`.
- `overrun`  out  1: sticky; a new burst started before the previous one completed.

## Operation

- Delay line: MAX_LAT-deep shift register of `read_issue`. The start tap is the stage delayed by `cas_lat` cycles. `cas_lat` = 0 behaves as 1. `cas_lat` > MAX_LAT behaves as MAX_LAT. `cas_lat` changes only while idle; a change with reads in flight gives an unspecified window but must not hang the FSM.
- FSM states:
  - IDLE: on start tap, sample `{iddr_q0, iddr_q1}`, set beat counter to 1, go to CAPTURE.
  - CAPTURE: each cycle, sample and increment the counter (width log2(BURST)). In the cycle the counter reads BURST-1 (the last capture), go to IDLE unless the start tap is also high.
- Start tap in CAPTURE on the last-capture cycle: seamless back-to-back. Stay in CAPTURE, reset the counter to 1 next cycle, and produce no gap or error.
- Start tap in CAPTURE on any other cycle: set `overrun`, abandon the old burst (its remaining words are never emitted, and no `rd_last` is given for it), and restart the counter at 1. The sample in that cycle belongs to the new burst.
- `overrun` is set by the event and cleared by `clr_err`. If both happen in the same cycle, set wins.
- All outputs are registered. `rd_data` holds its last value when `rd_valid` is low.
- Reset (asynchronous, any time, including mid-burst): delay line cleared, FSM to IDLE, counter 0, and `rd_data`=0, `rd_valid`=0, `rd_last`=0, `overrun`=0. A burst interrupted by reset emits nothing further.

## Timing

- `read_issue` high in cycle 0 with `cas_lat`=L: the input pair is sampled at the end of cycles L..L+BURST-1.
- `rd_valid` is high in cycles L+1..L+BURST.
- `rd_last` is high in cycle L+BURST.
- Latency from sampled pair to output word is 1 cycle. Throughput is one word per cycle.
- Reads issued exactly BURST cycles apart give a continuous `rd_valid`, with `rd_last` every BURST cycles.
- `overrun` rises in the cycle after the offending start tap.

## Test plan

- Reset/idle: hold `sys_rst_n`=0, then release with no reads → all outputs 0 and stay 0 for 20 cycles.
- Single burst, L=3, BURST=4:
  - Stimulus: `read_issue` in cycle 0; in cycles 3..6 drive q1/q0 = 0x1111/0x2222, 0x3333/0x4444, 0x5555/0x6666, 0x7777/0x8888.
  - Required: `rd_valid` in cycles 4..7 with words 0x22221111, 0x44443333, 0x66665555, 0x88887777; `rd_last` only in cycle 7.
- Back-to-back: issues at cycles 0 and 4, L=2 → `rd_valid` continuous in cycles 3..10, `rd_last` in cycles 6 and 10, `overrun` stays 0.
- Overrun: issues at cycles 0 and 2, L=2 →
  - words in cycles 3, 4 from burst A, then 4 words from burst B in cycles 5..8;
  - `rd_last` only in cycle 8;
  - `overrun`=1 from cycle 5 until `clr_err`;
  - `clr_err` and a new overrun in the same cycle leave `overrun`=1.
- Latency sweep: repeat the single burst for L=1 and L=7 → first valid at cycles 2 and 8; `cas_lat`=0 behaves as L=1.
- Reset mid-burst: assert `sys_rst_n`=0 asynchronously in cycle 5 of the L=3 burst → outputs 0 immediately; after release, no residual words and a new read works normally.
